// File: rtl/jpeg_color_pkg.sv
// Shared colour-conversion constants and types for the JPEG colour path.
// Coefficients are the inverse BT.601 matrix scaled by 2^13.
package jpeg_color_pkg;

    localparam int FRAC       = 13;
    localparam int CHROMA_OFS = 128;

    localparam int COEF_CR_R = 11485;  // 1.402    * 2^13
    localparam int COEF_CB_G = 2819;   // 0.344136 * 2^13
    localparam int COEF_CR_G = 5850;   // 0.714136 * 2^13
    localparam int COEF_CB_B = 14516;  // 1.772    * 2^13

    // Packed 3x8-bit pixel; component order depends on the colour space.
    typedef logic [23:0] pixel24_t;

    // Fixed-point intermediate: worst case is about 3.93e6, so 24 bits signed.
    typedef logic signed [23:0] sum24_t;

endpackage

// File: rtl/ycbcr2rgb_clamp_u8.sv
// Rescale a fixed-point colour sum to an integer and clamp it to 0..255.
// The sat flag reports that clamping changed the value.
module clamp_u8 #(
    parameter int FRAC = jpeg_color_pkg::FRAC
) (
    input  logic signed [23:0] sum,
    output logic        [7:0]  pix,
    output logic               sat
);
    import jpeg_color_pkg::*;

    sum24_t shifted;

    // Arithmetic shift keeps the sign so negative sums stay negative.
    assign shifted = sum >>> FRAC;

    // Clamp to the unsigned 8-bit range and flag any clipping.
    always_comb begin
        pix = shifted[7:0];
        sat = 1'b0;
        if (shifted < 0) begin
            pix = 8'd0;
            sat = 1'b1;
        end else if (shifted > 24'sd255) begin
            pix = 8'd255;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/ycbcr2rgb.sv
// YCbCr -> RGB inverse colour converter, 3-stage valid/ready pipeline.
// Input  {Cr, Cb, Y}, output {B, G, R}; counts clamped components.
//
// Handshake: a word moves across an interface only on a rising edge where
// valid and ready are both high. out_valid/out_data hold while stalled.
// Each stage loads when empty or when its content leaves on the same edge,
// so bubbles collapse and a full pipeline streams one pixel per cycle.
module ycbcr2rgb #(
    parameter int FRAC  = jpeg_color_pkg::FRAC,
    parameter int SAT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out_data,
    input  logic             sat_clr,
    output logic [SAT_W-1:0] sat_count
);
    import jpeg_color_pkg::*;

    localparam sum24_t K_CR_R = sum24_t'(COEF_CR_R);
    localparam sum24_t K_CB_G = sum24_t'(COEF_CB_G);
    localparam sum24_t K_CR_G = sum24_t'(COEF_CR_G);
    localparam sum24_t K_CB_B = sum24_t'(COEF_CB_B);
    localparam sum24_t OFS    = sum24_t'(CHROMA_OFS);
    localparam sum24_t ROUND  = sum24_t'(1) <<< (FRAC - 1);

    // Stage valids and the per-stage load strobes.
    logic v1, v2, v3;
    logic load1, load2, load3;

    // Stage registers.
    sum24_t   pr, pgb, pgr, pb, y8;
    sum24_t   rs, gs, bs;
    pixel24_t out_q;

    // Input component decode.
    sum24_t y_in, cb, cr;

    // S3 clamp results.
    logic [7:0] r8, g8, b8;
    logic       sat_r, sat_g, sat_b;
    logic [1:0] events;
    logic [SAT_W:0] sat_sum;

    // Back-to-front advance chain; depends only on valids and out_ready.
    assign load3    = v2 && (!v3 || out_ready);
    assign load2    = v1 && (!v2 || load3);
    assign in_ready = !v1 || load2;
    assign load1    = in_valid && in_ready;

    assign out_valid = v3;
    assign out_data  = out_q;

    assign y_in = sum24_t'({16'd0, in_data[7:0]});
    assign cb   = sum24_t'({16'd0, in_data[15:8]}) - OFS;
    assign cr   = sum24_t'({16'd0, in_data[23:16]}) - OFS;

    // Stage occupancy: set on load, cleared when the content moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (load1)      v1 <= 1'b1;
            else if (load2) v1 <= 1'b0;
            if (load2)      v2 <= 1'b1;
            else if (load3) v2 <= 1'b0;
            if (load3)          v3 <= 1'b1;
            else if (out_ready) v3 <= 1'b0;
        end
    end

    // S1: chroma products and scaled luma.
    always_ff @(posedge clk) begin
        if (load1) begin
            pr  <= cr * K_CR_R;
            pgb <= cb * K_CB_G;
            pgr <= cr * K_CR_G;
            pb  <= cb * K_CB_B;
            y8  <= y_in <<< FRAC;
        end
    end

    // S2: rounded fixed-point component sums.
    always_ff @(posedge clk) begin
        if (load2) begin
            rs <= y8 + pr + ROUND;
            gs <= y8 - pgb - pgr + ROUND;
            bs <= y8 + pb + ROUND;
        end
    end

    clamp_u8 #(.FRAC(FRAC)) u_clamp_r (.sum(rs), .pix(r8), .sat(sat_r));
    clamp_u8 #(.FRAC(FRAC)) u_clamp_g (.sum(gs), .pix(g8), .sat(sat_g));
    clamp_u8 #(.FRAC(FRAC)) u_clamp_b (.sum(bs), .pix(b8), .sat(sat_b));

    assign events  = {1'b0, sat_r} + {1'b0, sat_g} + {1'b0, sat_b};
    assign sat_sum = {1'b0, sat_count} + {{(SAT_W - 1){1'b0}}, events};

    // S3: clamped RGB output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (load3) begin
            out_q <= {b8, g8, r8};
        end
    end

    // Clamp-event counter: clear wins, otherwise saturating add on S3 load.
    always_ff @(posedge clk) begin
        if (rst || sat_clr) begin
            sat_count <= '0;
        end else if (load3) begin
            sat_count <= sat_sum[SAT_W] ? '1 : sat_sum[SAT_W-1:0];
        end
    end

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Self-checking bench for ycbcr2rgb: directed pixels with hand-computed
// results, backpressure, random valid/ready traffic, encoder round trip,
// counter saturation and mid-stream reset, all scored against a model.
module tb_ycbcr2rgb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = 24'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_data;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_count;

  ycbcr2rgb #(.FRAC(13), .SAT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // Stimulus entries: {roundtrip_flag, orig {B,G,R}, pixel {Cr,Cb,Y}}.
  logic [48:0] stim_q[$];
  int          rd_idx = 0;
  int          valid_pct = 100;
  int          ready_pct = 100;

  logic [23:0] exp_q[$];
  logic [24:0] orig_q[$];
  bit          acc_in = 1'b0;
  int          acc_cnt = 0;
  int          out_cnt = 0;
  int          sat_exp = 0;
  bit          held_v = 1'b0;
  logic [23:0] held_d = 24'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Inverse BT.601 at 2^13 scale, rounded, then clipped to 0..255.
  function automatic logic [23:0] model(input logic [23:0] p, output int ev);
    int y, cb, cr;
    int c[3];
    y  = int'(p[7:0]);
    cb = int'(p[15:8]) - 128;
    cr = int'(p[23:16]) - 128;
    c[0] = (y * 8192 + 11485 * cr + 4096) >>> 13;
    c[1] = (y * 8192 - 2819 * cb - 5850 * cr + 4096) >>> 13;
    c[2] = (y * 8192 + 14516 * cb + 4096) >>> 13;
    ev = 0;
    for (int i = 0; i < 3; i++) begin
      if (c[i] < 0) begin
        c[i] = 0;
        ev++;
      end else if (c[i] > 255) begin
        c[i] = 255;
        ev++;
      end
    end
    return {c[2][7:0], c[1][7:0], c[0][7:0]};
  endfunction

  function automatic logic [7:0] q8(input real x);
    int v;
    v = $rtoi(x + 0.5);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  // Encoder-side forward conversion (real arithmetic), {Cr,Cb,Y}.
  function automatic logic [23:0] rgb2ycc(input int r, input int g, input int b);
    real y, cb, cr;
    y  = 0.299 * r + 0.587 * g + 0.114 * b;
    cb = 128.0 - 0.168736 * r - 0.331264 * g + 0.5 * b;
    cr = 128.0 + 0.5 * r - 0.418688 * g - 0.081312 * b;
    return {q8(cr), q8(cb), q8(y)};
  endfunction

  // ---------------- driver (posedge + 1) ----------------
  always @(posedge clk) begin
    #1;
    out_ready = (int'($urandom_range(0, 99)) < ready_pct);
    if (rst) begin
      in_valid = 1'b0;
      rd_idx = stim_q.size();
    end else begin
      if (acc_in) begin
        rd_idx++;
        in_valid = 1'b0;
      end
      if (!in_valid && rd_idx < stim_q.size() &&
          int'($urandom_range(0, 99)) < valid_pct) begin
        in_valid = 1'b1;
        in_data = stim_q[rd_idx][23:0];
      end
    end
  end

  // ---------------- monitor / scoreboard (negedge) ----------------
  always @(negedge clk) begin
    logic [23:0] e;
    logic [24:0] o;
    int ev, d;
    bit ok;
    acc_in = 1'b0;
    if (rst) begin
      exp_q.delete();
      orig_q.delete();
      held_v = 1'b0;
      sat_exp = 0;
    end else begin
      if (sat_clr) sat_exp = 0;
      if (held_v) chk("hold_stable", {7'd0, out_valid, out_data}, {7'd0, 1'b1, held_d});
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          o = orig_q.pop_front();
          chk("out_data", {8'd0, out_data}, {8'd0, e});
          if (o[24]) begin
            ok = 1'b1;
            for (int i = 0; i < 3; i++) begin
              d = int'(out_data[8*i +: 8]) - int'(o[8*i +: 8]);
              if (d > 2 || d < -2) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL roundtrip: got %0h expected %0h +-2", out_data, o[23:0]);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        acc_in = 1'b1;
        acc_cnt++;
        exp_q.push_back(model(in_data, ev));
        orig_q.push_back(stim_q[rd_idx][48:24]);
        sat_exp = (sat_exp + ev > 65535) ? 65535 : sat_exp + ev;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int pending();
    return stim_q.size() - rd_idx;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((pending() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drain_done"}, (n < budget) ? 1 : 0, 1);
    repeat (3) tick();
  endtask

  task automatic send_one(input string name, input logic [23:0] pix,
                          input logic [23:0] exp_pix, input int exp_sat,
                          input bit clr_mid);
    int c0, n;
    tick();
    ready_pct = 100;
    valid_pct = 100;
    c0 = acc_cnt;
    stim_q.push_back({25'd0, pix});
    n = 0;
    while (acc_cnt == c0 && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_accepted"}, (n < 50) ? 1 : 0, 1);
    n = 0;
    do begin
      tick();
      n++;
      if (clr_mid && n == 2) sat_clr = 1'b1;
      if (n == 3) sat_clr = 1'b0;
    end while (!out_valid && n < 10);
    sat_clr = 1'b0;
    chk({name, "_latency"}, n, 3);
    chk({name, "_data"}, {8'd0, out_data}, {8'd0, exp_pix});
    drain(name, 100);
    chk({name, "_sat"}, {16'd0, sat_count}, exp_sat);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int o0, c0, r, g, b;

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_data", {8'd0, out_data}, 0);
    chk("rst_sat_count", {16'd0, sat_count}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    rst = 1'b0;

    // Directed pixels, {Cr,Cb,Y} -> {B,G,R}.
    send_one("gray", 24'h808080, 24'h808080, 0, 1'b0);
    send_one("sat_high", 24'hFF80FF, 24'hFFA4FF, 1, 1'b0);
    send_one("sat_low", 24'h000000, 24'h008700, 3, 1'b0);
    send_one("clr_vs_inc", 24'h000000, 24'h008700, 0, 1'b1);

    // Backpressure: output stalled, ten distinct pixels offered.
    tick();
    ready_pct = 0;
    valid_pct = 100;
    c0 = acc_cnt;
    o0 = out_cnt;
    for (int i = 0; i < 10; i++) stim_q.push_back({25'd0, 24'h102030 + 24'(i * 24'h050709)});
    repeat (8) tick();
    chk("bp_accepts", acc_cnt - c0, 3);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_out_valid", {31'd0, out_valid}, 1);
    ready_pct = 100;
    drain("bp", 200);
    chk("bp_out_count", out_cnt - o0, 10);

    // Random traffic with random valid/ready.
    valid_pct = 60;
    ready_pct = 50;
    for (int i = 0; i < 2000; i++) stim_q.push_back({25'd0, 24'($urandom())});
    repeat (1500) tick();
    valid_pct = 90;
    ready_pct = 80;
    drain("random", 20000);

    // Round trip through the encoder's forward matrix.
    valid_pct = 100;
    ready_pct = 100;
    chk("fwd_red", {8'd0, rgb2ycc(255, 0, 0)}, {8'd0, 24'hFF554C});
    stim_q.push_back({1'b1, 24'h0000FF, rgb2ycc(255, 0, 0)});
    for (int i = 0; i < 999; i++) begin
      r = int'($urandom_range(0, 255));
      g = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      stim_q.push_back({1'b1, 8'(b), 8'(g), 8'(r), rgb2ycc(r, g, b)});
    end
    drain("roundtrip", 5000);

    // Counter saturation: 32768 pixels with two clamps each.
    for (int i = 0; i < 32768; i++) stim_q.push_back({25'd0, 24'h000000});
    drain("satcnt", 40000);
    chk("sat_stick_model", {16'd0, sat_count}, sat_exp);
    chk("sat_stick", {16'd0, sat_count}, 32'h0000FFFF);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    tick();
    chk("sat_clr", {16'd0, sat_count}, 0);

    // Reset with all stages full.
    ready_pct = 0;
    for (int i = 0; i < 5; i++) stim_q.push_back({25'd0, 24'($urandom())});
    repeat (8) tick();
    chk("full_before_rst", {31'd0, out_valid}, 1);
    o0 = out_cnt;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_sat_count", {16'd0, sat_count}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    rst = 1'b0;
    ready_pct = 100;
    repeat (20) tick();
    chk("midrst_no_stale", out_cnt - o0, 0);
    for (int i = 0; i < 20; i++) stim_q.push_back({25'd0, 24'($urandom())});
    drain("after_rst", 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
